// File: rtl/mul_arbiter.sv
// Round-robin front end that shares one fixed-latency multiplier between NUM_REQ requesters,
// with a single-entry result slot per requester so the multiplier pipeline never stalls.
module mul_arbiter #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]            resp_valid,
  input  logic [NUM_REQ-1:0]            resp_ready,
  output logic [NUM_REQ*DATA_WIDTH-1:0] resp_data,
  output logic [DATA_WIDTH-1:0]         mul_a,
  output logic [DATA_WIDTH-1:0]         mul_b,
  input  logic [DATA_WIDTH-1:0]         mul_prod,
  output logic                          active
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, INFLIGHT, DONE} slot_t;

  slot_t            slot_q [NUM_REQ];
  slot_t            slot_d [NUM_REQ];
  logic [IW-1:0]    rr_ptr;
  logic [NUM_REQ-1:0] eligible;
  logic             grant_valid;
  logic [IW-1:0]    grant_idx;
  logic [IW-1:0]    cand;
  logic [MUL_LATENCY:0] tag_valid;
  logic [IW-1:0]    tag_idx [MUL_LATENCY+1];
  logic             cap_valid;
  logic [IW-1:0]    cap_idx;

  assign cap_valid = tag_valid[MUL_LATENCY];
  assign cap_idx   = tag_idx[MUL_LATENCY];

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    req_ready   = '0;
    for (int i = 0; i < NUM_REQ; i++)
      eligible[i] = req_valid[i] && (slot_q[i] == IDLE);
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
    if (grant_valid)
      req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    resp_valid = '0;
    active     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      slot_d[i] = slot_q[i];
      case (slot_q[i])
        IDLE:     if (grant_valid && grant_idx == IW'(i)) slot_d[i] = INFLIGHT;
        INFLIGHT: if (cap_valid && cap_idx == IW'(i))     slot_d[i] = DONE;
        DONE:     if (resp_ready[i])                      slot_d[i] = IDLE;
        default:  slot_d[i] = IDLE;
      endcase
      resp_valid[i] = (slot_q[i] == DONE);
      if (slot_q[i] != IDLE)
        active = 1'b1;
    end
  end

  // Reset clears the tag pipe, so a product still inside the multiplier is never captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++)
        slot_q[i] <= IDLE;
      rr_ptr    <= IW'(NUM_REQ - 1);
      mul_a     <= '0;
      mul_b     <= '0;
      tag_valid <= '0;
      for (int s = 0; s <= MUL_LATENCY; s++)
        tag_idx[s] <= '0;
      resp_data <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        slot_q[i] <= slot_d[i];
      mul_a <= '0;
      mul_b <= '0;
      if (grant_valid) begin
        rr_ptr <= grant_idx;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant_idx == IW'(i)) begin
            mul_a <= req_a[i*DATA_WIDTH +: DATA_WIDTH];
            mul_b <= req_b[i*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
      tag_valid[0] <= grant_valid;
      tag_idx[0]   <= grant_idx;
      for (int s = 1; s <= MUL_LATENCY; s++) begin
        tag_valid[s] <= tag_valid[s-1];
        tag_idx[s]   <= tag_idx[s-1];
      end
      for (int i = 0; i < NUM_REQ; i++)
        if (cap_valid && cap_idx == IW'(i))
          resp_data[i*DATA_WIDTH +: DATA_WIDTH] <= mul_prod;
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter with a Q8.8 one-stage multiplier model on the shared port.
module tb_mul_arbiter;
  localparam int DW = 16;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic rst;
  logic [NR-1:0]    req_valid, req_ready, resp_valid, resp_ready;
  logic [NR*DW-1:0] req_a, req_b, resp_data;
  logic [DW-1:0]    mul_a, mul_b, mul_prod;
  logic             active;

  logic [DW-1:0] exp_in [NR];
  logic [DW-1:0] expq [NR][$];
  int n_cmp  = 0;
  int n_fail = 0;
  int grants [NR];
  int total;

  mul_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MUL_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .mul_a(mul_a), .mul_b(mul_b), .mul_prod(mul_prod), .active(active)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] qmul(logic [15:0] a, logic [15:0] b);
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return p[23:8];
  endfunction

  always @(posedge clk)
    mul_prod <= qmul(mul_a, mul_b);

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Products are checked whenever a requester consumes one; grants enqueue what that op must return.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NR; i++) begin
        if (resp_valid[i] && resp_ready[i]) begin
          if (expq[i].size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL unexpected_resp%0d: got 0x%0h, expected no response", i,
                     resp_data[i*DW +: DW]);
          end else
            checkOutput($sformatf("resp_data%0d", i), 64'(resp_data[i*DW +: DW]), 64'(expq[i].pop_front()));
        end
        if (req_valid[i] && req_ready[i])
          expq[i].push_back(exp_in[i]);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(int i, logic [15:0] a, logic [15:0] b, logic [15:0] e);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
    exp_in[i]         = e;
    req_valid[i]      = 1'b1;
  endtask

  task automatic waitResp(int i);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid[i] && n < 20);
    checkOutput($sformatf("wait_resp%0d", i), 64'(resp_valid[i]), 64'(1));
  endtask

  task automatic applyStream();
    applyStimulus(0, 16'h0100, 16'h0280, 16'h0280);
    applyStimulus(1, 16'h0080, 16'h0400, 16'h0200);
    applyStimulus(2, 16'hFE00, 16'hFF80, 16'h0100);
    applyStimulus(3, 16'h0300, 16'hFF00, 16'hFD00);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = '0;
    req_a      = '0;
    req_b      = '0;
    for (int i = 0; i < NR; i++) exp_in[i] = '0;
    tick();
    tick();
    @(negedge clk);
    checkOutput("reset_req_ready", 64'(req_ready), 64'(0));
    checkOutput("reset_resp", 64'({resp_valid, resp_data}), 64'(0));
    checkOutput("reset_mul", 64'({mul_a, mul_b, active}), 64'(0));
    tick();
    rst = 1'b0;

    // Lone request from requester 0, product observed two edges after the accept edge.
    tick();
    applyStimulus(0, 16'h0200, 16'h0180, 16'h0300);
    @(negedge clk);
    checkOutput("t1_grant", 64'(req_ready), 64'(4'b0001));
    tick();
    req_valid = '0;
    @(negedge clk);
    checkOutput("t1_mul_issue", 64'({mul_a, mul_b}), 64'({16'h0200, 16'h0180}));
    @(negedge clk);
    checkOutput("t1_not_yet", 64'(resp_valid), 64'(0));
    @(negedge clk);
    checkOutput("t1_resp_valid", 64'(resp_valid), 64'(4'b0001));
    checkOutput("t1_active", 64'(active), 64'(1));
    tick();
    resp_ready = 4'b1111;
    repeat (2) tick();

    // Signed product for requester 2.
    applyStimulus(2, 16'hFF00, 16'h0200, 16'hFE00);
    @(negedge clk);
    checkOutput("t2_grant", 64'(req_ready), 64'(4'b0100));
    tick();
    req_valid = '0;
    repeat (5) tick();

    // Requester 3 consumes and re-requests in the same cycle: no grant until the next one.
    resp_ready[3] = 1'b0;
    applyStimulus(3, 16'h0100, 16'h0100, 16'h0100);
    @(negedge clk);
    checkOutput("t5_first_grant", 64'(req_ready), 64'(4'b1000));
    tick();
    req_valid = '0;
    waitResp(3);
    tick();
    resp_ready[3] = 1'b1;
    applyStimulus(3, 16'h0180, 16'h0200, 16'h0300);
    @(negedge clk);
    checkOutput("t5_no_same_cycle", 64'(req_ready), 64'(0));
    tick();
    @(negedge clk);
    checkOutput("t5_next_grant", 64'(req_ready), 64'(4'b1000));
    tick();
    req_valid = '0;
    repeat (5) tick();

    // All four streaming with every result consumed immediately.
    applyStream();
    for (int i = 0; i < NR; i++) grants[i] = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c < 4)
        checkOutput($sformatf("t3_order%0d", c), 64'(req_ready), 64'(4'b0001 << c));
      for (int i = 0; i < NR; i++) if (req_ready[i]) grants[i]++;
      tick();
    end
    for (int i = 0; i < NR; i++)
      checkOutput($sformatf("t3_fair%0d", i), 64'(grants[i] >= 4), 64'(1));

    // Requester 1 holds its result; the others keep flowing around it.
    resp_ready = 4'b1101;
    waitResp(1);
    total = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      @(negedge clk);
      checkOutput($sformatf("t4_blocked%0d", c), 64'({req_ready[1], resp_valid[1]}), 64'(2'b01));
      checkOutput($sformatf("t4_hold%0d", c), 64'(resp_data[31:16]), 64'(16'h0200));
      for (int i = 0; i < NR; i++) if (req_ready[i]) total++;
    end
    checkOutput("t4_others_granted", 64'(total >= 3), 64'(1));
    tick();
    resp_ready = 4'b1111;
    repeat (2) tick();
    req_valid = '0;
    repeat (6) tick();
    for (int i = 0; i < NR; i++)
      checkOutput($sformatf("drain%0d", i), 64'(expq[i].size()), 64'(0));

    // Reset in the middle of three operations.
    resp_ready = '0;
    applyStimulus(0, 16'h0100, 16'h0100, 16'h0100);
    applyStimulus(1, 16'h0200, 16'h0100, 16'h0200);
    applyStimulus(2, 16'h0300, 16'h0100, 16'h0300);
    total = 0;
    for (int c = 0; c < 10 && total < 3; c++) begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) if (req_ready[i]) total++;
      tick();
    end
    checkOutput("t6_three_issued", 64'(total), 64'(3));
    rst       = 1'b1;
    req_valid = '0;
    for (int i = 0; i < NR; i++) expq[i].delete();
    tick();
    rst        = 1'b0;
    resp_ready = 4'b1111;
    @(negedge clk);
    checkOutput("t6_rst_resp", 64'({resp_valid, resp_data}), 64'(0));
    checkOutput("t6_rst_mul", 64'({mul_a, mul_b, active, req_ready}), 64'(0));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput($sformatf("t6_no_resp%0d", c), 64'(resp_valid), 64'(0));
    end
    tick();
    applyStream();
    @(negedge clk);
    checkOutput("t6_first_grant", 64'(req_ready), 64'(4'b0001));
    repeat (12) tick();
    req_valid = '0;
    repeat (6) tick();
    for (int i = 0; i < NR; i++)
      checkOutput($sformatf("final_drain%0d", i), 64'(expq[i].size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
